// File: rtl/chrisruk_matrix_rx.sv
// chrisruk_matrix_rx: clock/data LED-strip frame receiver rebuilding a 64-pixel bitmap; SNAKE_UNMAP_EN enables snake-to-raster indexing
module chrisruk_matrix_rx #(
  parameter int          NUM_LEDS  = 64,
  parameter logic [31:0] ON_COLOUR = 32'hf00f0000,
  parameter int          SOF_ZEROS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strip_clk,
  input  logic        strip_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [5:0]  led_idx,
  output logic        frame_done,
  output logic [63:0] pixels,
  output logic        hdr_err,
  output logic        busy
);
  localparam int ZW = $clog2(SOF_ZEROS + 1);
  typedef enum logic [1:0] {HUNT, SOF, LED} state_t;
  state_t         state_q;
  logic [2:0]     sclk_q;
  logic [1:0]     sdat_q;
  logic           ev_q, bit_q;
  logic [ZW-1:0]  zcnt_q, zcnt_d;
  logic [4:0]     bitcnt_q;
  logic [5:0]     pos_q, idx_d;
  logic [30:0]    shift_q;
  logic [31:0]    word_d;
  logic [63:0]    shadow_q, shadow_d;
  logic           hdr_ok, last;
  always_comb begin
    word_d = {shift_q, bit_q};
`ifdef SNAKE_UNMAP_EN
    idx_d = pos_q[3] ? pos_q : {pos_q[5:3], ~pos_q[2:0]};
`else
    idx_d = pos_q;
`endif
    shadow_d = shadow_q;
    shadow_d[idx_d] = (word_d == ON_COLOUR);
    hdr_ok = (word_d[31:29] == 3'b111);
    last = (pos_q == 6'(NUM_LEDS - 1));
    zcnt_d = (zcnt_q == ZW'(SOF_ZEROS)) ? zcnt_q : zcnt_q + 1'b1;
  end
  // bit events are re-registered so pulses land on the third edge after strip_clk is first sampled high
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      sclk_q     <= '0;
      sdat_q     <= '0;
      ev_q       <= 1'b0;
      bit_q      <= 1'b0;
      zcnt_q     <= '0;
      bitcnt_q   <= '0;
      pos_q      <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
      led_idx    <= '0;
      frame_done <= 1'b0;
      pixels     <= '0;
      hdr_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[1:0], strip_clk};
      sdat_q     <= {sdat_q[0], strip_data};
      ev_q       <= sclk_q[1] & ~sclk_q[2];
      bit_q      <= sdat_q[1];
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      if (ev_q) begin
        case (state_q)
          HUNT: begin
            zcnt_q <= bit_q ? '0 : zcnt_d;
            if (!bit_q && zcnt_d == ZW'(SOF_ZEROS)) state_q <= SOF;
          end
          SOF: if (bit_q) begin
            state_q  <= LED;
            busy     <= 1'b1;
            bitcnt_q <= 5'd1;
            pos_q    <= '0;
            shift_q  <= 31'd1;
          end
          LED: begin
            shift_q  <= word_d[30:0];
            bitcnt_q <= bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd31) begin
              if (!hdr_ok) begin
                hdr_err  <= 1'b1;
                shadow_q <= '0;
                zcnt_q   <= '0;
                state_q  <= HUNT;
                busy     <= 1'b0;
              end else begin
                word_valid <= 1'b1;
                word       <= word_d;
                led_idx    <= idx_d;
                pos_q      <= pos_q + 6'd1;
                shadow_q   <= last ? '0 : shadow_d;
                if (last) begin
                  pixels     <= shadow_d;
                  frame_done <= 1'b1;
                  zcnt_q     <= '0;
                  state_q    <= HUNT;
                  busy       <= 1'b0;
                end
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
endmodule
